// File: rtl/sdes_pkg.sv
// Shared types for the circular shift engine: FSM state encoding and
// rotate-direction constants.
package sdes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rotate_step_seg.sv
// Combinational one-position rotate applied independently to each equal
// segment of a word; bits never cross a segment boundary.
module rotate_step_seg
    import sdes_pkg::*;
#(
    parameter int WIDTH        = 10,
    parameter int NUM_SEGMENTS = 2
) (
    input  logic [WIDTH-1:0] word,
    input  logic             dir,
    output logic [WIDTH-1:0] rotated
);

    localparam int SEG_W = WIDTH / NUM_SEGMENTS;

    // Modulo indexing keeps the SEG_W == 1 case a clean passthrough.
    always_comb begin
        rotated = '0;
        for (int k = 0; k < NUM_SEGMENTS; k++) begin
            for (int j = 0; j < SEG_W; j++) begin
                if (dir == DIR_LEFT) begin
                    rotated[k*SEG_W + j] = word[k*SEG_W + ((j + SEG_W - 1) % SEG_W)];
                end else begin
                    rotated[k*SEG_W + j] = word[k*SEG_W + ((j + 1) % SEG_W)];
                end
            end
        end
    end

endmodule

// File: rtl/circular_shift_engine.sv
// Multi-cycle segmented rotator: accepts a word, rotates each segment one
// position per cycle, then holds the result under valid/ready handshaking.
module circular_shift_engine
    import sdes_pkg::*;
#(
    parameter int WIDTH        = 10,
    parameter int NUM_SEGMENTS = 2,
    localparam int SEG_W       = WIDTH / NUM_SEGMENTS,
    localparam int AMT_W       = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [AMT_W-1:0] i_amount,
    input  logic             i_dir,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy
);

    state_t             state, state_next;
    logic [AMT_W-1:0]   cnt, cnt_next;
    logic [WIDTH-1:0]   work, work_next;
    logic               dir_q, dir_next;
    logic [WIDTH-1:0]   stepped;
    logic [AMT_W-1:0]   amt_eff;
    logic               accept;

    // Full rotations of a segment are no-ops, so only the remainder is worked off.
    assign amt_eff = AMT_W'(i_amount % AMT_W'(SEG_W));
    assign accept  = i_valid & o_ready;

    rotate_step_seg #(
        .WIDTH        (WIDTH),
        .NUM_SEGMENTS (NUM_SEGMENTS)
    ) u_step (
        .word    (work),
        .dir     (dir_q),
        .rotated (stepped)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        work_next  = work;
        dir_next   = dir_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    work_next  = i_data;
                    dir_next   = i_dir;
                    cnt_next   = amt_eff;
                    state_next = (amt_eff == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_next = stepped;
                cnt_next  = cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so each one is a flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            work    <= '0;
            dir_q   <= DIR_LEFT;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            work    <= work_next;
            dir_q   <= dir_next;
            o_valid <= (state_next == DONE);
            o_ready <= (state_next == IDLE);
            o_busy  <= (state_next != IDLE);
            if ((state != DONE) && (state_next == DONE)) begin
                o_data <= work_next;
            end
        end
    end

endmodule

// File: tb/tb_circular_shift_engine.sv
// Directed and random checks of circular_shift_engine against a per-segment
// rotate model, with results matched through an expected-value queue.
module tb_circular_shift_engine;

    localparam int WIDTH        = 10;
    localparam int NUM_SEGMENTS = 2;
    localparam int SEG_W        = WIDTH / NUM_SEGMENTS;
    localparam int AMT_W        = $clog2(WIDTH + 1);

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic [AMT_W-1:0] i_amount;
    logic             i_dir;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_busy;

    int checks   = 0;
    int failures = 0;
    bit hold_mode = 1'b0;

    logic [WIDTH-1:0] exp_data_q[$];
    int               exp_lat_q[$];

    circular_shift_engine #(
        .WIDTH        (WIDTH),
        .NUM_SEGMENTS (NUM_SEGMENTS)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_amount (i_amount),
        .i_dir    (i_dir),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int amt, input logic dir);
        logic [WIDTH-1:0] r;
        logic [SEG_W-1:0] s;
        int a;
        a = amt % SEG_W;
        r = '0;
        for (int k = 0; k < NUM_SEGMENTS; k++) begin
            s = d[k*SEG_W +: SEG_W];
            if (!dir) r[k*SEG_W +: SEG_W] = (s << a) | (s >> (SEG_W - a));
            else      r[k*SEG_W +: SEG_W] = (s >> a) | (s << (SEG_W - a));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input int amt, input logic dir);
        int  budget;
        bit  acc;
        i_valid  = 1'b1;
        i_data   = d;
        i_amount = AMT_W'(amt);
        i_dir    = dir;
        exp_data_q.push_back(model(d, amt, dir));
        exp_lat_q.push_back((amt % SEG_W) + 1);
        budget = 0;
        acc    = 1'b0;
        while (!acc && budget < 50) begin
            acc = o_ready;
            @(posedge i_clk); #1;
            budget++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        if (!hold_mode) i_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 1;
        while (!o_valid && lat < 40) begin
            chk("busy_while_shifting", {31'd0, o_busy}, 32'd1);
            if (hold_mode) begin
                i_data   = WIDTH'($urandom);
                i_amount = AMT_W'($urandom_range(0, WIDTH));
                i_dir    = 1'($urandom);
            end
            @(posedge i_clk); #1;
            lat++;
        end
        if (!o_valid) chk("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkOutput(input int lat, input int stall);
        logic [WIDTH-1:0] exp;
        int               exp_lat;
        exp     = exp_data_q.pop_front();
        exp_lat = exp_lat_q.pop_front();
        chk("result_data", 32'(o_data), 32'(exp));
        chk("result_latency", 32'(lat), 32'(exp_lat));
        chk("ready_low_in_done", {31'd0, o_ready}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(posedge i_clk); #1;
            chk("stall_valid", {31'd0, o_valid}, 32'd1);
            chk("stall_data", 32'(o_data), 32'(exp));
            chk("stall_ready", {31'd0, o_ready}, 32'd0);
        end
        i_ready = 1'b1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk("release_valid", {31'd0, o_valid}, 32'd0);
        chk("release_ready", {31'd0, o_ready}, 32'd1);
        chk("release_busy", {31'd0, o_busy}, 32'd0);
        chk("idle_keeps_data", 32'(o_data), 32'(exp));
    endtask

    task automatic runOne(input logic [WIDTH-1:0] d, input int amt, input logic dir, input int stall);
        int lat;
        applyStimulus(d, amt, dir);
        waitResult(lat);
        checkOutput(lat, stall);
    endtask

    initial begin
        int seen;
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_data   = '0;
        i_amount = '0;
        i_dir    = 1'b0;
        i_ready  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("reset_ready", {31'd0, o_ready}, 32'd1);
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_data", 32'(o_data), 32'd0);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);

        runOne(10'b10000_00001, 1, 1'b0, 0);
        runOne(10'b10100_00111, 2, 1'b0, 1);
        runOne(10'b10000_00001, 1, 1'b1, 0);
        runOne(10'b10100_00111, 7, 1'b0, 0);
        runOne(10'b11011_00101, 0, 1'b0, 3);
        runOne(10'b01101_10010, 10, 1'b1, 0);
        runOne(10'b01101_10010, 4, 1'b1, 2);
        runOne(10'b11100_00011, 9, 1'b0, 0);

        // Reset in the middle of a rotation must drop the request silently.
        applyStimulus(10'b10110_01011, 4, 1'b0);
        @(posedge i_clk); #1;
        chk("busy_before_reset", {31'd0, o_busy}, 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        exp_data_q.delete();
        exp_lat_q.delete();
        chk("midreset_valid", {31'd0, o_valid}, 32'd0);
        chk("midreset_data", 32'(o_data), 32'd0);
        chk("midreset_ready", {31'd0, o_ready}, 32'd1);
        chk("midreset_busy", {31'd0, o_busy}, 32'd0);
        seen = 0;
        repeat (8) begin
            @(posedge i_clk); #1;
            if (o_valid) seen++;
        end
        chk("no_result_after_reset", 32'(seen), 32'd0);

        hold_mode = 1'b1;
        for (int n = 0; n < 20; n++) begin
            runOne(WIDTH'($urandom), int'($urandom_range(0, WIDTH)), 1'($urandom), int'($urandom_range(0, 2)));
        end
        hold_mode = 1'b0;
        chk("scoreboard_empty", 32'(exp_data_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/circular_shift_engine.md
CIRCULAR_SHIFT_ENGINE -- requirements
Module: circular_shift_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 10, total data width in bits.
REQ-002 SHALL have parameter NUM_SEGMENTS, default 2, count of independently rotated equal segments; WIDTH % NUM_SEGMENTS == 0.
REQ-003 SHALL derive local constants SEG_W = WIDTH/NUM_SEGMENTS and AMT_W = $clog2(WIDTH+1).
REQ-004 i_clk  input  1  sole clock, rising edge.
REQ-005 i_rst  input  1  reset; synchronous and active-high.
REQ-006 i_valid  input  1  request valid.
REQ-007 o_ready  output  1  engine can accept request.
REQ-008 i_data  input  WIDTH  word to rotate.
REQ-009 i_amount  input  AMT_W  rotate distance, in bit positions.
REQ-010 i_dir  input  1  0 = left, 1 = right.
REQ-011 o_valid  output  1  result valid.
REQ-012 i_ready  input  1  consumer accepts result.
REQ-013 o_data  output  WIDTH  rotated word.
REQ-014 o_busy  output  1  high in SHIFT or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-016 SHALL assert o_ready only in IDLE; accept = i_valid & o_ready at a rising edge.
REQ-017 On accept, SHALL register i_data, i_dir and effective amount amt_eff = i_amount % SEG_W.
REQ-018 On accept, SHALL go to DONE if amt_eff == 0, else to SHIFT with counter = amt_eff.
REQ-019 In SHIFT, SHALL rotate each segment by exactly one position per cycle in the latched direction and decrement the counter.
REQ-020 SHALL rotate segments independently: no bit crosses a segment boundary; segment k occupies bits [k*SEG_W +: SEG_W].
REQ-021 SHALL go from SHIFT to DONE on the cycle the counter reaches 0.
REQ-022 SHALL assert o_valid in DONE only; o_valid rises exactly amt_eff + 1 cycles after the accept edge.
REQ-023 SHALL hold o_data and o_valid stable while o_valid & !i_ready (backpressure, any duration).
REQ-024 SHALL return to IDLE on the edge where o_valid & i_ready; o_ready rises on the following cycle.
REQ-025 SHALL ignore i_valid, i_data, i_amount, i_dir outside IDLE.
REQ-026 SHALL keep o_data equal to the last result while in IDLE.
REQ-027 NUM_SEGMENTS == 1 SHALL give a plain full-width rotator; SEG_W == 1 SHALL give identity output after 1 cycle.

Reset
REQ-028 i_rst high at a rising edge SHALL force IDLE, o_valid = 0, o_data = 0, counter = 0, o_busy = 0, from any state.
REQ-029 Reset during SHIFT or DONE SHALL drop the in-flight request with no o_valid pulse.
REQ-030 o_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-031 State enum (IDLE/SHIFT/DONE) and direction constants SHALL live in the shared package sdes_pkg.
REQ-032 SHALL instantiate one combinational sub-module, rotate_step_seg, which performs a one-position, per-segment rotate in either direction on a WIDTH-bit word.
REQ-033 SHALL register all outputs; no combinational path from i_data to o_data.

Verification (WIDTH=10, NUM_SEGMENTS=2)
REQ-034 i_data=10'b10000_00001, amt 1, left -> o_data 10'b00001_00010, o_valid at accept+2.
REQ-035 i_data=10'b10100_00111, amt 2, left -> o_data 10'b10010_11100, o_valid at accept+3.
REQ-036 i_data=10'b10000_00001, amt 1, right -> 10'b01000_10000; amt 7 left on 10'b10100_00111 -> same as amt 2, latency 3.
REQ-037 amt 0 -> o_data == i_data at accept+1; i_ready low 3 cycles -> o_data/o_valid stable, o_ready low until accept+5.
REQ-038 i_rst pulsed in SHIFT (amt 4) -> next cycle o_valid=0, o_data=0, o_ready=1; no result emitted.
REQ-039 Random i_data/amount/dir vs. a reference model, with i_valid held during busy -> every result matches, one result per accept.
